lif_layer_seq: RTL
==================

LIF_LAYER_SEQ -- requirements
Module: lif_layer_seq

Interface
REQ-001 SHALL have parameter M, default 8: number of input spikes (synapses per neuron), M>=1.
REQ-002 SHALL have parameter N, default 8: number of neurons, N>=1.
REQ-003 SHALL have parameter VW, default 6: membrane potential and threshold width.
REQ-004 SHALL have parameter DW, default 3: decay width.
REQ-005 SHALL have parameter RW, default 5: refractory period width.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-008 SHALL have port reset  input  1  synchronous active-high reset.
REQ-009 SHALL have port start  input  1  request one timestep evaluation.
REQ-010 SHALL have port clear  input  1  zero all membrane and refractory state.
REQ-011 SHALL have port input_spikes  input  M  spike vector for the timestep.
REQ-012 SHALL have port weights  input  N*M*2  per-synapse weight; neuron j, input i at bits [(j*M+i)*2 +: 2]; bit1 = nonzero, bit0 = sign (1 = negative).
REQ-013 SHALL have port threshold  input  VW  firing threshold, shared by all neurons.
REQ-014 SHALL have port decay  input  DW  leak subtracted per timestep.
REQ-015 SHALL have port refractory_period  input  RW  timesteps held silent after a spike.
REQ-016 SHALL have port busy  output  1  evaluation in progress.
REQ-017 SHALL have port output_data_ready  output  1  one-cycle pulse; results valid.
REQ-018 SHALL have port output_spikes  output  N  registered spike vector of last completed timestep.
REQ-019 SHALL have port membrane_potential_out  output  N*VW  neuron j at bits [j*VW +: VW], debug.

Function
REQ-020 SHALL implement FSM states IDLE, ACCUM, UPDATE, DONE; reset enters IDLE.
REQ-021 SHALL, in IDLE with start=1, capture input_spikes into an internal register, clear neuron index and accumulator, go to ACCUM; cycle of capture = cycle 0.
REQ-022 SHALL, in ACCUM, process one synapse per cycle for the current neuron, input index 0..M-1: if captured spike=1 and weight bit1=1, add +1 (bit0=0) or -1 (bit0=1) to a signed accumulator wide enough for -M..+M; after input M-1 go to UPDATE.
REQ-023 SHALL, in UPDATE for neuron j: if refractory counter>0, decrement it, hold V=0, spike_j=0; else tmp = V + acc - decay in signed arithmetic wide enough to avoid overflow, clamped to [0, 2^VW-1]; if tmp >= threshold (unsigned) then spike_j=1, V=0, counter=refractory_period; else V=tmp, spike_j=0.
REQ-024 SHALL, after UPDATE, go to ACCUM for neuron j+1 with accumulator cleared, or to DONE after neuron N-1.
REQ-025 SHALL, in DONE, assert output_data_ready for exactly one cycle, load output_spikes with all N new spike bits simultaneously, return to IDLE.
REQ-026 SHALL assert busy in ACCUM and UPDATE only: cycles 1..N*(M+1); output_data_ready at cycle N*(M+1)+1.
REQ-027 SHALL ignore start while not in IDLE; no queuing.
REQ-028 SHALL sample weights, threshold, decay, refractory_period live; caller holds them stable while busy.
REQ-029 SHALL honour clear only in IDLE: V and refractory counters to 0, output_spikes to 0; clear and start both high in IDLE: clear wins, start dropped.
REQ-030 SHALL drive membrane_potential_out directly from the membrane registers.
REQ-031 SHALL treat threshold=0 as firing every non-refractory timestep; refractory_period=0 as no silence.

Reset
REQ-032 SHALL, on reset=1 at any state including mid-evaluation, set state IDLE, busy=0, output_data_ready=0, output_spikes=0, all V=0, all refractory counters=0, accumulator and indices=0.

Verification (M=4, N=2, VW=6)
REQ-033 SHALL cover: reset asserted mid-ACCUM at cycle 5 -> next cycle busy=0, all outputs 0, next start gives a fresh 11-cycle evaluation.
REQ-034 SHALL cover: all weights 2'b10, threshold=3, decay=0, spikes 4'b1111, start -> output_data_ready at cycle 11, output_spikes=2'b11, V=0 both.
REQ-035 SHALL cover: threshold=10, decay=1, same stimulus, four timesteps -> V=3,6,9 then spike on 4th with V=0.
REQ-036 SHALL cover: refractory_period=2, threshold=3 -> spike, then two timesteps spikes=0 and V=0, then spike again on the 4th.
REQ-037 SHALL cover: weights 2'b11 -> V clamps at 0, no spike; threshold=63, decay=0, weights +1 -> V saturates at 63, spike, V=0.
REQ-038 SHALL cover: start pulsed at cycle 4 while busy -> ignored, exactly one output_data_ready; clear with start in IDLE -> no evaluation, V=0.

Source files
------------

// File: rtl/lif_layer_seq.sv
// Sequential leaky integrate-and-fire layer: N neurons, M ternary-weighted
// synapses each, evaluated one synapse per cycle and one neuron update per
// M+1 cycles; results published together with a single-cycle ready pulse.
module lif_layer_seq #(
    parameter int M  = 8,
    parameter int N  = 8,
    parameter int VW = 6,
    parameter int DW = 3,
    parameter int RW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clear,
    input  logic [M-1:0]      input_spikes,
    input  logic [N*M*2-1:0]  weights,
    input  logic [VW-1:0]     threshold,
    input  logic [DW-1:0]     decay,
    input  logic [RW-1:0]     refractory_period,
    output logic              busy,
    output logic              output_data_ready,
    output logic [N-1:0]      output_spikes,
    output logic [N*VW-1:0]   membrane_potential_out
);

    localparam int AW  = $clog2(M + 1) + 1;
    localparam int TW  = ((VW > DW) ? VW : DW) + AW + 2;
    localparam int IIW = (M > 1) ? $clog2(M) : 1;
    localparam int NIW = (N > 1) ? $clog2(N) : 1;
    localparam logic signed [TW-1:0] VMAX = $signed({{(TW-VW){1'b0}}, {VW{1'b1}}});

    typedef enum logic [1:0] {IDLE, ACCUM, UPDATE, DONE} state_t;

    state_t                  state_q;
    logic [M-1:0]            spk_q;
    logic [IIW-1:0]          iidx_q;
    logic [NIW-1:0]          nidx_q;
    logic signed [AW-1:0]    acc_q;
    logic [N-1:0][VW-1:0]    v_q;
    logic [N-1:0][RW-1:0]    ref_q;
    logic [N-1:0]            new_q;
    logic [N-1:0]            out_q;
    logic                    odr_q;

    logic [1:0]              w_cur;
    logic signed [AW-1:0]    acc_d;
    logic signed [TW-1:0]    v_ext;
    logic signed [TW-1:0]    acc_ext;
    logic signed [TW-1:0]    dec_ext;
    logic signed [TW-1:0]    tmp;
    logic [VW-1:0]           v_clamp;
    logic                    in_refr;
    logic                    fire;
    logic [N-1:0]            new_d;

    assign busy                   = (state_q == ACCUM) || (state_q == UPDATE);
    assign output_data_ready      = odr_q;
    assign output_spikes          = out_q;
    assign membrane_potential_out = v_q;

    // Accumulator step: add the current synapse's ternary contribution
    always_comb begin
        w_cur = weights[2*(int'(nidx_q)*M + int'(iidx_q)) +: 2];
        acc_d = acc_q;
        if (spk_q[iidx_q] && w_cur[1]) begin
            acc_d = w_cur[0] ? (acc_q - $signed(AW'(1))) : (acc_q + $signed(AW'(1)));
        end
    end

    // Membrane update for the current neuron: leak, clamp, threshold test
    always_comb begin
        v_ext   = $signed({{(TW-VW){1'b0}}, v_q[nidx_q]});
        acc_ext = $signed({{(TW-AW){acc_q[AW-1]}}, acc_q});
        dec_ext = $signed({{(TW-DW){1'b0}}, decay});
        tmp     = v_ext + acc_ext - dec_ext;
        if (tmp[TW-1]) begin
            v_clamp = '0;
        end else if (tmp > VMAX) begin
            v_clamp = '1;
        end else begin
            v_clamp = tmp[VW-1:0];
        end
        in_refr = (ref_q[nidx_q] != '0);
        fire    = !in_refr && (v_clamp >= threshold);
        new_d          = new_q;
        new_d[nidx_q]  = fire;
    end

    // Control FSM and all neuron state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            spk_q   <= '0;
            iidx_q  <= '0;
            nidx_q  <= '0;
            acc_q   <= '0;
            v_q     <= '0;
            ref_q   <= '0;
            new_q   <= '0;
            out_q   <= '0;
            odr_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clear) begin
                        v_q   <= '0;
                        ref_q <= '0;
                        out_q <= '0;
                    end else if (start) begin
                        spk_q   <= input_spikes;
                        iidx_q  <= '0;
                        nidx_q  <= '0;
                        acc_q   <= '0;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_d;
                    if (iidx_q == IIW'(M - 1)) begin
                        iidx_q  <= '0;
                        state_q <= UPDATE;
                    end else begin
                        iidx_q <= iidx_q + IIW'(1);
                    end
                end
                UPDATE: begin
                    if (in_refr) begin
                        ref_q[nidx_q] <= ref_q[nidx_q] - RW'(1);
                        v_q[nidx_q]   <= '0;
                    end else if (fire) begin
                        v_q[nidx_q]   <= '0;
                        ref_q[nidx_q] <= refractory_period;
                    end else begin
                        v_q[nidx_q]   <= v_clamp;
                    end
                    new_q <= new_d;
                    acc_q <= '0;
                    if (nidx_q == NIW'(N - 1)) begin
                        // publish all spike bits at once, including the one decided this cycle
                        out_q   <= new_d;
                        odr_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        nidx_q  <= nidx_q + NIW'(1);
                        state_q <= ACCUM;
                    end
                end
                DONE: begin
                    odr_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
